alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
Shares one combinational ALU datapath between two requesters: the pipeline EX stage (requester 0) and a multi-cycle helper unit (requester 1). The block accepts operand/op requests over valid/ready and arbitrates round-robin. It drives the shared ALU's A/B/alu_ctrl inputs, captures result and zero flag into a per-requester response register, and returns them over valid/ready. Per-requester saturating stall counters support performance debug.

Parameters:
WIDTH, 32, operand/result width
CNT_W, 16, width of each stall counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  WIDTH  operand A
req0_b  input  WIDTH  operand B
req0_ctrl  input  3  ALU op (010 ADD, 110 SUB, 000 AND, 001 OR)
resp0_valid  output  1  response 0 holds a result
resp0_ready  input  1  requester 0 consumes response
resp0_result  output  WIDTH  captured ALU result
resp0_zero  output  1  captured zero flag
req1_valid, req1_ready, req1_a, req1_b, req1_ctrl  as requester 0
resp1_valid, resp1_ready, resp1_result, resp1_zero  as response 0
alu_a  output  WIDTH  to shared ALU operand A
alu_b  output  WIDTH  to shared ALU operand B
alu_ctrl  output  3  to shared ALU op select
alu_result  input  WIDTH  from shared ALU (combinational)
alu_zero  input  1  from shared ALU (combinational)
stall0_cnt  output  CNT_W  cycles req0 was valid but not granted
stall1_cnt  output  CNT_W  same for req1

Behaviour:
- Reset (rst=1 at a clk edge): resp*_valid=0, resp*_result=0, resp*_zero=0, stall*_cnt=0, last_grant=1 (requester 0 wins the first tie). Pending responses are dropped. A request presented in the same cycle as reset is not accepted: req*_ready=0 while rst=1.
- Eligibility: elig_i = req_i_valid && (!resp_i_valid || resp_i_ready). A requester whose response slot is full and not draining this cycle cannot be granted.
- Grant (combinational):
  - Both eligible: grant the requester != last_grant.
  - Exactly one eligible: grant it.
  - None eligible: no grant.
  - At most one grant per cycle.
- req_i_ready = grant_i. Ready may depend on valid.
- Requester duty: hold a/b/ctrl stable while valid && !ready.
- ALU drive: alu_a/alu_b/alu_ctrl equal the granted requester's payload. With no grant: alu_a=0, alu_b=0, alu_ctrl=3'b010.
- last_grant updates at the clock edge only on a grant cycle.
- Response register i, priority order per edge:
  - grant_i: load resp_i_result=alu_result, resp_i_zero=alu_zero, resp_i_valid=1.
  - Else if resp_i_valid && resp_i_ready: resp_i_valid=0. Data holds its last value.
  - Else: hold all fields.
- Latency: accepted in cycle N gives resp_i_valid=1 in cycle N+1. Sustained throughput is 1 op/cycle per requester with resp_ready=1, or 1 op/cycle total when both request continuously (alternating).
- Simultaneous pop and grant on the same requester: the new result replaces the consumed one and valid stays 1 (no bubble).
- Stall counter i: increments when req_i_valid && !grant_i && !rst. It saturates at all-ones and never wraps.
- Widths: all datapath is WIDTH bits. The ALU does the arithmetic; the block performs no arithmetic on data. Counters are unsigned CNT_W.

Test Plan:
- ADD: req0 a=5 b=3 ctrl=010 alone, resp0_ready=1 -> req0_ready=1 in cycle N; resp0_valid=1, result=8, zero=0 in N+1; stall0_cnt=0.
- SUB zero flag: req1 a=7 b=7 ctrl=110 -> resp1_result=0, resp1_zero=1 one cycle after grant.
- Tie after reset: both valid continuously for 4 ops each (req0 AND 0xF0&0x3C, req1 OR 0x1|0x2) -> grants alternate 0,1,0,1...; first results 0x30 then 0x3; stall0_cnt=3, stall1_cnt=4 at the end.
- Backpressure: resp0 valid with resp0_ready=0, req0 valid a=1 b=1 for 3 cycles -> req0_ready=0, resp0_result held, stall0_cnt=3; req1 still granted. Raising resp0_ready grants req0 that cycle; result=2 next cycle.
- Saturation (CNT_W=4): hold req0 valid blocked for 20 cycles -> stall0_cnt reaches 15 and stays 15.
- Reset mid-operation: assert rst the cycle after a grant with resp_ready=0 -> next edge gives resp0_valid=0, result=0, counters 0, last_grant=1; a subsequent tie grants req0 first.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Bus bundle between the two ALU requesters, the shared ALU and the arbiter.
// The arbiter connects through the slave modport; the environment
// (requesters, ALU, debug logic) connects through the master modport.
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [2:0]       req0_ctrl;
  logic             resp0_valid;
  logic             resp0_ready;
  logic [WIDTH-1:0] resp0_result;
  logic             resp0_zero;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [2:0]       req1_ctrl;
  logic             resp1_valid;
  logic             resp1_ready;
  logic [WIDTH-1:0] resp1_result;
  logic             resp1_zero;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  logic [CNT_W-1:0] stall0_cnt;
  logic [CNT_W-1:0] stall1_cnt;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctrl, resp0_ready,
    input  req1_valid, req1_a, req1_b, req1_ctrl, resp1_ready,
    input  alu_result, alu_zero,
    output req0_ready, resp0_valid, resp0_result, resp0_zero,
    output req1_ready, resp1_valid, resp1_result, resp1_zero,
    output alu_a, alu_b, alu_ctrl,
    output stall0_cnt, stall1_cnt
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctrl, resp0_ready,
    output req1_valid, req1_a, req1_b, req1_ctrl, resp1_ready,
    output alu_result, alu_zero,
    input  req0_ready, resp0_valid, resp0_result, resp0_zero,
    input  req1_ready, resp1_valid, resp1_result, resp1_zero,
    input  alu_a, alu_b, alu_ctrl,
    input  stall0_cnt, stall1_cnt
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the EX stage
// (requester 0) and a helper unit (requester 1). Each requester owns a
// one-entry response register and a saturating stall counter for debug.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);
  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [2:0]       CtrlAdd = 3'b010;

  logic             w_elig0;
  logic             w_elig1;
  logic             w_grant0;
  logic             w_grant1;

  logic             r_lastGrant;
  logic             r_resp0Valid;
  logic [WIDTH-1:0] r_resp0Result;
  logic             r_resp0Zero;
  logic             r_resp1Valid;
  logic [WIDTH-1:0] r_resp1Result;
  logic             r_resp1Zero;
  logic [CNT_W-1:0] r_stall0Cnt;
  logic [CNT_W-1:0] r_stall1Cnt;

  // A requester may win only if its response slot is empty or draining now;
  // on a tie the one that did not win last time goes, and nothing wins in reset.
  always_comb begin
    w_elig0  = bus.req0_valid && (!r_resp0Valid || bus.resp0_ready);
    w_elig1  = bus.req1_valid && (!r_resp1Valid || bus.resp1_ready);
    w_grant0 = !rst && w_elig0 && (!w_elig1 || r_lastGrant);
    w_grant1 = !rst && w_elig1 && (!w_elig0 || !r_lastGrant);
  end

  // Steer the winner's payload to the shared ALU; idle drive is 0 + 0 (ADD).
  always_comb begin
    bus.alu_a    = '0;
    bus.alu_b    = '0;
    bus.alu_ctrl = CtrlAdd;
    if (w_grant0) begin
      bus.alu_a    = bus.req0_a;
      bus.alu_b    = bus.req0_b;
      bus.alu_ctrl = bus.req0_ctrl;
    end else if (w_grant1) begin
      bus.alu_a    = bus.req1_a;
      bus.alu_b    = bus.req1_b;
      bus.alu_ctrl = bus.req1_ctrl;
    end
  end

  // Arbitration history, response capture/drain and stall accounting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lastGrant   <= 1'b1;
      r_resp0Valid  <= 1'b0;
      r_resp0Result <= '0;
      r_resp0Zero   <= 1'b0;
      r_resp1Valid  <= 1'b0;
      r_resp1Result <= '0;
      r_resp1Zero   <= 1'b0;
      r_stall0Cnt   <= '0;
      r_stall1Cnt   <= '0;
    end else begin
      if (w_grant0) begin
        r_lastGrant <= 1'b0;
      end else if (w_grant1) begin
        r_lastGrant <= 1'b1;
      end

      if (w_grant0) begin
        r_resp0Valid  <= 1'b1;
        r_resp0Result <= bus.alu_result;
        r_resp0Zero   <= bus.alu_zero;
      end else if (r_resp0Valid && bus.resp0_ready) begin
        r_resp0Valid  <= 1'b0;
      end

      if (w_grant1) begin
        r_resp1Valid  <= 1'b1;
        r_resp1Result <= bus.alu_result;
        r_resp1Zero   <= bus.alu_zero;
      end else if (r_resp1Valid && bus.resp1_ready) begin
        r_resp1Valid  <= 1'b0;
      end

      if (bus.req0_valid && !w_grant0 && (r_stall0Cnt != CntMax)) begin
        r_stall0Cnt <= r_stall0Cnt + CntOne;
      end
      if (bus.req1_valid && !w_grant1 && (r_stall1Cnt != CntMax)) begin
        r_stall1Cnt <= r_stall1Cnt + CntOne;
      end
    end
  end

  assign bus.req0_ready   = w_grant0;
  assign bus.req1_ready   = w_grant1;
  assign bus.resp0_valid  = r_resp0Valid;
  assign bus.resp0_result = r_resp0Result;
  assign bus.resp0_zero   = r_resp0Zero;
  assign bus.resp1_valid  = r_resp1Valid;
  assign bus.resp1_result = r_resp1Result;
  assign bus.resp1_zero   = r_resp1Zero;
  assign bus.stall0_cnt   = r_stall0Cnt;
  assign bus.stall1_cnt   = r_stall1Cnt;
endmodule
